// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per cycle, LSB slice first.
// Latency K = WIDTH/DIGIT edges after acceptance; holds result in DONE until out_ready.
module digit_serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);
  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_y;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [DIGIT:0]   w_sum;
  logic             w_msb_cin;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  assign w_sum     = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  // Carry into the top bit of the slice recovered from its sum bit and operand bits.
  assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_sum[DIGIT-1];
  assign w_last    = (r_cnt == CW'(K - 1));

  generate
    if (K == 1) begin : g_single
      assign w_acc_next = w_sum[DIGIT-1:0];
    end else begin : g_multi
      assign w_acc_next = {w_sum[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_y         <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b ^ {WIDTH{sub}};
            r_carry    <= sub;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        BUSY: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_sum[DIGIT];
          r_acc   <= w_acc_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_y         <= w_acc_next;
            r_cout      <= w_sum[DIGIT];
            r_ovf       <= w_msb_cin ^ w_sum[DIGIT];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
endmodule

// File: doc/digit_serial_addsub.md
DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL provide parameter DIGIT, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, with K = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port y  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE, both registered.
REQ-016 Input handshake SHALL occur on a rising edge with in_valid & in_ready; it latches a, b XOR {WIDTH{sub}}, carry-in = sub, clears digit counter, enters BUSY.
REQ-017 a, b, sub SHALL be sampled only at the input handshake edge; later changes SHALL have no effect.
REQ-018 in_valid while not in IDLE SHALL be ignored; no operand queueing.
REQ-019 In BUSY, each rising edge SHALL add one DIGIT-bit slice, LSB slice first, using the carry register and storing DIGIT result bits plus the updated carry.
REQ-020 Digit counter SHALL run 0..K-1; the edge processing slice K-1 SHALL also load cout, compute ovf = (carry into MSB) XOR (carry out of MSB), and enter DONE.
REQ-021 out_valid SHALL rise exactly K rising edges after the input handshake edge.
REQ-022 In DONE, y, cout, ovf SHALL hold stable until the output handshake (out_valid & out_ready on a rising edge), which SHALL return the FSM to IDLE.
REQ-023 y, cout, ovf SHALL retain their last values in IDLE and BUSY; they are meaningful only while out_valid = 1.
REQ-024 With in_valid and out_ready held high, throughput SHALL be one operation per K+2 cycles.
REQ-025 DIGIT = WIDTH (K = 1) SHALL be legal: out_valid one edge after acceptance.
REQ-026 Result SHALL be bit-exact with {cout,y} = a + (sub ? ~b : b) + sub over WIDTH+1 bits.

Reset
REQ-027 While rst_n = 0: state = IDLE, in_ready = 0, out_valid = 0, y = 0, cout = 0, ovf = 0, counter and carry = 0, independent of clk.
REQ-028 in_ready SHALL rise on the first rising edge with rst_n = 1.
REQ-029 Reset asserted in BUSY or DONE SHALL abort the operation; no partial result SHALL later be presented.

Verification (WIDTH=8, DIGIT=4, K=2)
REQ-030 a=0x7F, b=0x01, sub=0 -> y=0x80, cout=0, ovf=1; out_valid 2 edges after acceptance.
REQ-031 a=0x00, b=0x01, sub=1 -> y=0xFF, cout=0, ovf=0; a=0x80, b=0x01, sub=1 -> y=0x7F, cout=1, ovf=1.
REQ-032 out_ready held low 5 cycles in DONE, with in_valid high and a/b toggling -> y/cout/ovf stable, in_ready=0, no second acceptance.
REQ-033 rst_n pulsed low during BUSY -> all outputs 0 immediately; in_ready=1 one edge after release; next op a=0x10, b=0x20, sub=0 -> y=0x30, cout=0, ovf=0.
REQ-034 in_valid and out_ready constantly high, 4 random ops -> acceptances exactly 4 cycles apart, each result equals REQ-026 reference.
REQ-035 Randomised scoreboard, WIDTH=32/DIGIT=8 and WIDTH=8/DIGIT=8, random ready/valid stalls -> all results match REQ-026, no handshake dropped or duplicated.
